// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word width, idle fill word and frame state encoding
package spi_pkg;

  localparam int                  SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_FILL  = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser for an async pin with rise/fall pulses
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  // Reset to the pin's idle level so leaving reset never produces an edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/spi_tx_buffer.sv
// rtl/spi_tx_buffer.sv - SPI mode-0 slave transmitter with one-entry holding register
// Define SPI_TX_UNDERRUN_CNT_EN to add a saturating 16-bit underrun counter output.
module spi_tx_buffer
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter logic [WIDTH-1:0] FILL        = SPI_FILL,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sck,
  input  logic             i_cs,
  output logic             o_do,
  output logic             o_doe,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic             o_sent,
`ifdef SPI_TX_UNDERRUN_CNT_EN
  output logic             o_underrun,
  output logic [15:0]      o_underrun_count
`else
  output logic             o_underrun
`endif
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  spi_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CW-1:0]    r_bitcnt, w_bitcnt_next;
  logic             r_reload, w_reload_next;
  logic [WIDTH-1:0] r_hold, w_hold_next;
  logic             r_hold_valid, w_hold_valid_next;
  logic             r_sent, w_sent_next;
  logic             r_underrun, w_underrun_next;
  logic             w_load, w_wr;
  logic             w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  assign w_wr = i_tx_valid & ~r_hold_valid;

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_reload_next = r_reload;
    w_sent_next   = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load        = 1'b1;
          w_bitcnt_next = '0;
          w_state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // Deselect wins over any SCK edge seen in the same cycle
        if (w_cs_rise) begin
          w_state_next  = IDLE;
          w_bitcnt_next = '0;
          w_reload_next = 1'b0;
        end else if (w_sck_rise) begin
          if (r_bitcnt == LAST) begin
            w_bitcnt_next = '0;
            w_sent_next   = 1'b1;
            w_reload_next = 1'b1;
          end else begin
            w_bitcnt_next = r_bitcnt + 1'b1;
          end
        end else if (w_sck_fall) begin
          if (r_reload) begin
            w_load        = 1'b1;
            w_reload_next = 1'b0;
          end else begin
            w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_load) begin
      w_shift_next = r_hold_valid ? r_hold : FILL;
    end
  end

  // Loads see only the registered holding entry; a same-cycle write lands for the next word
  assign w_underrun_next   = w_load & ~r_hold_valid;
  assign w_hold_valid_next = w_wr | (r_hold_valid & ~w_load);
  assign w_hold_next       = w_wr ? i_tx_data : r_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_reload     <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_sent       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bitcnt     <= w_bitcnt_next;
      r_reload     <= w_reload_next;
      r_hold       <= w_hold_next;
      r_hold_valid <= w_hold_valid_next;
      r_sent       <= w_sent_next;
      r_underrun   <= w_underrun_next;
    end
  end

  assign o_do       = (r_state == SHIFT) ? r_shift[WIDTH-1] : 1'b0;
  assign o_doe      = (r_state == SHIFT);
  assign o_tx_ready = ~r_hold_valid;
  assign o_sent     = r_sent;
  assign o_underrun = r_underrun;

`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_underrun_cnt <= '0;
    end else if (r_underrun && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign o_underrun_count = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_spi_tx_buffer.sv
// tb/tb_spi_tx_buffer.sv - scoreboard bench for spi_tx_buffer with a queue-based reference model
module tb_spi_tx_buffer;

  localparam int         WIDTH = 8;
  localparam logic [7:0] FILL  = 8'hFF;
  localparam int         HALF  = 10;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       i_rst, i_sck, i_cs, i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_do, o_doe, o_tx_ready, o_sent, o_underrun;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [15:0] o_underrun_count;
  int          ucnt_model = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         mon_underruns = 0;
  int         model_underruns = 0;
  logic [7:0] hold_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  chk_t       chk_q[$];
  logic [7:0] rx_word = '0;
  int         rx_bits = 0;

  always #5 clk = ~clk;

  spi_tx_buffer dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_sck      (i_sck),
    .i_cs       (i_cs),
    .o_do       (o_do),
    .o_doe      (o_doe),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_sent     (o_sent),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .o_underrun (o_underrun),
    .o_underrun_count (o_underrun_count)
`else
    .o_underrun (o_underrun)
`endif
  );

  // Master-side sampler: captures DO on each SCK rise, drops partial words on deselect
  always @(posedge i_sck or posedge i_cs) begin
    if (i_cs) begin
      rx_bits = 0;
    end else if (o_doe) begin
      rx_word = {rx_word[6:0], o_do};
      rx_bits = rx_bits + 1;
      if (rx_bits == WIDTH) begin
        rx_q.push_back(rx_word);
        rx_bits = 0;
      end
    end
  end

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] e, a;
    if (o_underrun) mon_underruns = mon_underruns + 1;
    if (o_sent) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sent_unexpected actual=pulse required=none");
      end else begin
        e = exp_q.pop_front();
        a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        if (a !== e) begin
          errors = errors + 1;
          $display("FAIL sent_word actual=%0h required=%0h", a, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks = checks + 1;
      if (c.act !== c.exp) begin
        errors = errors + 1;
        $display("FAIL %s actual=%0h required=%0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  function automatic logic [7:0] mload();
    if (hold_q.size() > 0) return hold_q.pop_front();
    model_underruns = model_underruns + 1;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    if (ucnt_model < 16'hFFFF) ucnt_model = ucnt_model + 1;
`endif
    return FILL;
  endfunction

  task automatic wr(input logic [7:0] d);
    int t;
    t = 0;
    if (hold_q.size() != 0) return;
    while (!o_tx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!o_tx_ready) begin
      push_chk("wr_ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
    hold_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_cs  = 1'b1;
    i_sck = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    hold_q.delete();
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ucnt_model = 0;
`endif
  endtask

  task automatic frame(input int nbits, input int wr_at, input logic [7:0] wd, input bit rst_end);
    logic [7:0] cur;
    @(negedge clk);
    i_cs = 1'b0;
    cur = mload();
    repeat (6) @(negedge clk);
    push_chk("doe_active", {31'd0, o_doe}, 32'd1);
    push_chk("ready_after_load", {31'd0, o_tx_ready}, {31'd0, hold_q.size() == 0});
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (6) @(negedge clk);
      if (wr_at == i) wr(wd);
      repeat (4) @(negedge clk);
      i_sck = 1'b1;
      if (i % WIDTH == WIDTH - 1) exp_q.push_back(cur);
      repeat (HALF) @(negedge clk);
      if (i == nbits - 1 && !rst_end) begin
        i_cs = 1'b1;
        repeat (HALF) @(negedge clk);
        i_sck = 1'b0;
      end else begin
        i_sck = 1'b0;
        if (i % WIDTH == WIDTH - 1) cur = mload();
      end
    end
    if (rst_end) begin
      repeat (6) @(negedge clk);
      i_rst = 1'b1;
      i_cs  = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      push_chk("rst_do", {31'd0, o_do}, 32'd0);
      push_chk("rst_doe", {31'd0, o_doe}, 32'd0);
      push_chk("rst_ready", {31'd0, o_tx_ready}, 32'd1);
      hold_q.delete();
`ifdef SPI_TX_UNDERRUN_CNT_EN
      ucnt_model = 0;
`endif
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (20) @(negedge clk);
    push_chk({tag, "_underruns"}, mon_underruns, model_underruns);
    push_chk({tag, "_pending_words"}, exp_q.size(), 32'd0);
    push_chk({tag, "_ready"}, {31'd0, o_tx_ready}, {31'd0, hold_q.size() == 0});
    push_chk({tag, "_doe_idle"}, {31'd0, o_doe}, 32'd0);
    push_chk({tag, "_do_idle"}, {31'd0, o_do}, 32'd0);
`ifdef SPI_TX_UNDERRUN_CNT_EN
    push_chk({tag, "_ucnt"}, {16'd0, o_underrun_count}, ucnt_model);
`endif
  endtask

  initial begin
    int n, w;
    i_rst      = 1'b1;
    i_sck      = 1'b0;
    i_cs       = 1'b1;
    i_tx_valid = 1'b0;
    i_tx_data  = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    push_chk("reset_do", {31'd0, o_do}, 32'd0);
    push_chk("reset_doe", {31'd0, o_doe}, 32'd0);
    push_chk("reset_ready", {31'd0, o_tx_ready}, 32'd1);
    push_chk("reset_sent", {31'd0, o_sent}, 32'd0);
    push_chk("reset_underrun", {31'd0, o_underrun}, 32'd0);

    wr(8'h7A);
    frame(8, -1, 8'h00, 1'b0);
    settle("t1");

    wr(8'h80);
    frame(16, 2, 8'h0C, 1'b0);
    settle("t2");

    frame(8, -1, 8'h00, 1'b0);
    settle("t3");

    wr(8'h40);
    frame(3, -1, 8'h00, 1'b0);
    frame(8, 0, 8'h0C, 1'b0);
    settle("t4");

    frame(5, 0, 8'hA5, 1'b1);
    frame(8, -1, 8'h00, 1'b0);
    settle("t5");

`ifdef SPI_TX_UNDERRUN_CNT_EN
    do_reset();
    repeat (3) frame(8, -1, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    push_chk("ucnt_three", {16'd0, o_underrun_count}, 32'd3);
    do_reset();
    repeat (2) @(negedge clk);
    push_chk("ucnt_cleared", {16'd0, o_underrun_count}, 32'd0);
`endif

    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) wr(8'($urandom));
      n = $urandom_range(1, 24);
      w = $urandom_range(0, n);
      frame(n, w, 8'($urandom), 1'b0);
      settle("rand");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/spi_tx_buffer.md
Name: spi_tx_buffer

Overview:
SPI slave transmitter. It is the return-direction counterpart of the SPI receive buffer: it shifts bytes out on DO, MSB first, in SPI mode 0 (DO changes on SCK falling, master samples on SCK rising) while CS is low. The system side loads bytes through a one-entry valid/ready holding register, so the shift register and holding register form a double buffer. SCK and CS are asynchronous pins, oversampled and synchronised in the CLK domain.

Parameters:
WIDTH, 8, bits per SPI word; bit counter is $clog2(WIDTH) bits
FILL, 8'hFF, word shifted out when the holding register is empty at load time (WIDTH bits)
SYNC_STAGES, 2, synchroniser flops on SCK and CS (minimum 2)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
SCK  input  1  SPI clock from master, asynchronous
CS  input  1  SPI chip select, active-low, asynchronous
DO  output  1  serial data out; current shift-register MSB while active, 0 when idle
DOE  output  1  output enable for DO pad; 1 while synchronised CS is low
TxData  input  WIDTH  word to send
TxValid  input  1  TxData valid
TxReady  output  1  holding register empty; transfer when TxValid && TxReady
Sent  output  1  one-CLK pulse when the WIDTH-th SCK rising edge of a word is detected
Underrun  output  1  one-CLK pulse when FILL is loaded because the holding register was empty

Behaviour:
- Reset values: DO=0, DOE=0, TxReady=1, Sent=0, Underrun=0; hold_valid=0, shift=0, bitcnt=0, reload=0, state=IDLE. Synchroniser CS flops reset to 1, SCK flops reset to 0, so no spurious edges leave reset.
- sck_rise, sck_fall, cs_fall and cs_rise are derived from the last synchroniser stage and a previous-value flop.
- State IDLE:
  - On cs_fall: load shift from holding if hold_valid, else FILL with an Underrun pulse; clear hold_valid if used; bitcnt=0; go to SHIFT.
  - SCK edges are ignored in IDLE.
- State SHIFT:
  - On sck_rise: if bitcnt==WIDTH-1, then bitcnt=0, Sent=1 for one cycle, reload=1; else bitcnt++.
  - On sck_fall: if reload, load the next word (holding or FILL, with the same rules as IDLE) and clear reload; else shift left by 1, filling the LSB with 0.
  - On cs_rise: go to IDLE; clear bitcnt and reload; discard the partial word with no Sent; hold_valid is unchanged.
  - cs_rise has priority over an SCK edge detected in the same cycle.
- DO = shift[WIDTH-1] in SHIFT, 0 in IDLE. DOE = (state==SHIFT).
- Holding register and TxReady:
  - TxReady = !hold_valid.
  - A write sets hold_valid on the next cycle.
  - A load consumes only the registered hold_valid/hold; there is no bypass. A write in the same cycle as a load from an empty holding register sends FILL and lands in the holding register for the next word.
- Latency:
  - DO updates no later than SYNC_STAGES+2 CLK after a pin-level SCK falling edge.
  - Requirement: SCK high and low phases are each ≥ 2*(SYNC_STAGES+2) CLK periods, and CS setup before the first SCK edge is ≥ SYNC_STAGES+2 CLK periods.
- RST asserted mid-word returns to reset values in the next cycle; any pending holding data is dropped.

Optional Feature:
SPI_TX_UNDERRUN_CNT_EN:
- Defined: adds output UnderrunCount (16 bits), which increments on each Underrun pulse, saturates at 16'hFFFF, and resets to 0 on RST.
- Undefined: the port and counter are absent and the Underrun pulse alone is provided.

Decomposition:
- Package spi_pkg: default SPI word width (8), default FILL constant, state enum {IDLE, SHIFT}; shared with the receive buffer.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs, parameterised reset value. Instantiated once for SCK and once for CS.

Test Plan:
- Write 122 (0x7A) with CS high, drop CS, clock 8 SCK -> DO sequence 0,1,1,1,1,0,1,0 sampled on rises; one Sent pulse; TxReady back to 1 right after the cs_fall load.
- Preload 128, drop CS, write 12 during the first word, run 16 SCK -> DO carries 0x80 then 0x0C, two Sent pulses, no Underrun.
- CS low with empty holding register, 8 SCK -> DO carries 0xFF, Underrun pulses once at the cs_fall load.
- Load 64, raise CS after 3 SCK, lower CS, write 12, run 8 SCK -> no Sent for the aborted word; second frame sends FILL (64 was already consumed) and Underrun pulses; 12 remains held with TxReady=0.
- Assert RST after 5 SCK with holding full -> next cycle DO=0, DOE=0, TxReady=1; the next frame sends FILL.
- With SPI_TX_UNDERRUN_CNT_EN defined, run 3 underrun frames -> UnderrunCount=3; with RST -> 0.
